// File: rtl/spindle_core_if.sv
// spindle_core_if: request/response handshake between the scheduler and the shared spindle core
//   master (scheduler): drives core_start, core_chan, core_lce; receives core_done, core_ia, core_ii
//   slave  (core)     : the reverse direction
interface spindle_core_if #(parameter int CW = 3);
  logic          core_start;
  logic [CW-1:0] core_chan;
  logic [31:0]   core_lce;
  logic          core_done;
  logic [31:0]   core_ia;
  logic [31:0]   core_ii;
  modport master(output core_start, core_chan, core_lce, input core_done, core_ia, core_ii);
  modport slave(input core_start, core_chan, core_lce, output core_done, core_ia, core_ii);
endinterface

// File: rtl/spindle_scheduler.sv
// spindle_scheduler: time-multiplexes one shared spindle core across NCH muscle channels per tick
//   clk, reset (async active-low); tick/chan_en/lce_in start a frame from a snapshot;
//   core (master modport) issues one request per enabled channel; fr_ia_out/fr_ii_out hold
//   per-channel results; frame_done/busy/frame_cnt report progress; overrun/timeout_err are sticky.
module spindle_scheduler #(
  parameter int NCH     = 2,
  parameter int TIMEOUT = 1023,
  parameter int CW      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [NCH-1:0]    chan_en,
  input  logic [NCH*32-1:0] lce_in,
  spindle_core_if.master    core,
  output logic [NCH*32-1:0] fr_ia_out,
  output logic [NCH*32-1:0] fr_ii_out,
  output logic              frame_done,
  output logic              busy,
  output logic              overrun,
  output logic              timeout_err,
  output logic [31:0]       frame_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, DONE} state_t;
  state_t            r_state;
  logic [CW:0]       r_ch;
  logic [NCH-1:0]    r_en;
  logic [31:0]       r_lce_q [NCH];
  logic [TW-1:0]     r_cnt;
  logic              r_start, r_fdone, r_busy, r_ovr, r_to;
  logic [31:0]       r_lce, r_fcnt;
  logic [NCH*32-1:0] r_ia, r_ii;
  logic              w_en;
  logic [31:0]       w_lce;
  always_comb begin
    w_en  = 1'b0;
    w_lce = '0;
    for (int i = 0; i < NCH; i++)
      if (r_ch == (CW+1)'(i)) begin
        w_en  = r_en[i];
        w_lce = r_lce_q[i];
      end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_en    <= '0;
      for (int i = 0; i < NCH; i++) r_lce_q[i] <= '0;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_fdone <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
      r_to    <= 1'b0;
      r_lce   <= '0;
      r_fcnt  <= '0;
      r_ia    <= '0;
      r_ii    <= '0;
    end else begin
      r_start <= 1'b0;
      r_fdone <= 1'b0;
      // any tick outside IDLE (DONE included) is dropped and flagged
      if (tick && r_state != IDLE) r_ovr <= 1'b1;
      case (r_state)
        IDLE: if (tick) begin
          r_en <= chan_en;
          for (int i = 0; i < NCH; i++) r_lce_q[i] <= lce_in[32*i +: 32];
          r_ch    <= '0;
          r_busy  <= |chan_en;
          r_state <= |chan_en ? SCAN : DONE;
          r_fdone <= ~|chan_en;
          r_fcnt  <= r_fcnt + {31'd0, ~|chan_en};
        end
        SCAN: if (r_ch >= (CW+1)'(NCH)) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_fdone <= 1'b1;
          r_fcnt  <= r_fcnt + 32'd1;
        end else if (!w_en) r_ch <= r_ch + 1'b1;
        else begin
          r_state <= ISSUE;
          r_start <= 1'b1;
          r_lce   <= w_lce;
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: if (core.core_done) begin
          for (int i = 0; i < NCH; i++)
            if (r_ch == (CW+1)'(i)) begin
              r_ia[32*i +: 32] <= core.core_ia;
              r_ii[32*i +: 32] <= core.core_ii;
            end
          r_ch    <= r_ch + 1'b1;
          r_state <= SCAN;
        end else if (r_cnt == TW'(TIMEOUT - 1)) begin
          r_to    <= 1'b1;
          r_ch    <= r_ch + 1'b1;
          r_state <= SCAN;
        end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  assign core.core_start = r_start;
  assign core.core_chan  = r_ch[CW-1:0];
  assign core.core_lce   = r_lce;
  assign fr_ia_out       = r_ia;
  assign fr_ii_out       = r_ii;
  assign frame_done      = r_fdone;
  assign busy            = r_busy;
  assign overrun         = r_ovr;
  assign timeout_err     = r_to;
  assign frame_cnt       = r_fcnt;
endmodule

// File: tb/tb_spindle_scheduler.sv
// tb_spindle_scheduler: scoreboard bench for spindle_scheduler with a fixed-latency core model
module tb_spindle_scheduler;
  localparam int NCH = 2, CW = 3, L = 10;
  logic clk = 1'b0, reset = 1'b0, tick = 1'b0;
  logic [NCH-1:0] chan_en = '0;
  logic [NCH*32-1:0] lce_in = '0;
  logic [NCH*32-1:0] fr_ia_out, fr_ii_out;
  logic frame_done, busy, overrun, timeout_err;
  logic [31:0] frame_cnt;
  spindle_core_if #(.CW(CW)) core_if();
  spindle_scheduler #(.NCH(NCH), .TIMEOUT(1023), .CW(CW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .chan_en(chan_en), .lce_in(lce_in), .core(core_if),
    .fr_ia_out(fr_ia_out), .fr_ii_out(fr_ii_out), .frame_done(frame_done), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err), .frame_cnt(frame_cnt));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_pass = 0, t_tick = 0, skip_n = 0;
  logic [31:0] rsp_ia = '0, rsp_ii = '0;
  typedef struct {logic [CW-1:0] chan; logic [31:0] lce;} req_t;
  typedef struct {int t0; int lat; logic [31:0] cnt; logic [63:0] ia; logic [63:0] ii; logic to; logic ov;} frm_t;
  req_t req_q[$];
  frm_t frm_q[$];
  req_t r_exp;
  frm_t f_exp;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  initial begin
    core_if.core_done = 1'b0;
    core_if.core_ia = '0;
    core_if.core_ii = '0;
    forever begin
      @(negedge clk);
      if (core_if.core_start === 1'b1) begin
        if (skip_n > 0) skip_n--;
        else begin
          repeat (L) @(negedge clk);
          core_if.core_done = 1'b1;
          core_if.core_ia = rsp_ia;
          core_if.core_ii = rsp_ii;
          @(negedge clk);
          core_if.core_done = 1'b0;
        end
      end
    end
  end
  always @(negedge clk) begin
    if (core_if.core_start === 1'b1) begin
      if (req_q.size() == 0) chk("unexpected_core_start", {63'd0, core_if.core_start}, 64'd0);
      else begin
        r_exp = req_q.pop_front();
        chk("core_chan", {61'd0, core_if.core_chan}, {61'd0, r_exp.chan});
        chk("core_lce", {32'd0, core_if.core_lce}, {32'd0, r_exp.lce});
      end
    end
    if (frame_done === 1'b1) begin
      if (frm_q.size() == 0) chk("unexpected_frame_done", {63'd0, frame_done}, 64'd0);
      else begin
        f_exp = frm_q.pop_front();
        chk("frame_latency", 64'(cyc - f_exp.t0), 64'(f_exp.lat));
        chk("frame_cnt", {32'd0, frame_cnt}, {32'd0, f_exp.cnt});
        chk("fr_ia_out", fr_ia_out, f_exp.ia);
        chk("fr_ii_out", fr_ii_out, f_exp.ii);
        chk("timeout_err", {63'd0, timeout_err}, {63'd0, f_exp.to});
        chk("overrun", {63'd0, overrun}, {63'd0, f_exp.ov});
        chk("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end
  task automatic issue(input logic [NCH-1:0] en, input logic [63:0] lce);
    @(negedge clk);
    chan_en = en;
    lce_in = lce;
    tick = 1'b1;
    t_tick = cyc;
    @(negedge clk);
    tick = 1'b0;
  endtask
  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (frm_q.size() == 0 && req_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", {63'd0, frm_q.size() == 0 && req_q.size() == 0}, 64'd1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
    chk({tag, "_overrun"}, {63'd0, overrun}, 64'd0);
    chk({tag, "_timeout_err"}, {63'd0, timeout_err}, 64'd0);
    chk({tag, "_frame_cnt"}, {32'd0, frame_cnt}, 64'd0);
    chk({tag, "_fr_ia"}, fr_ia_out, 64'd0);
    chk({tag, "_fr_ii"}, fr_ii_out, 64'd0);
    chk({tag, "_core_start"}, {63'd0, core_if.core_start}, 64'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    rsp_ia = 32'h42480000; rsp_ii = 32'h41200000;
    issue(2'b11, {32'h3F99999A, 32'h3F800000});
    chk("busy_mid_frame", {63'd0, busy}, 64'd1);
    chan_en = 2'b00; lce_in = {32'hFFFFFFFF, 32'hFFFFFFFF};
    req_q.push_back('{3'd0, 32'h3F800000});
    req_q.push_back('{3'd1, 32'h3F99999A});
    frm_q.push_back('{t_tick, 26, 32'd1, {32'h42480000, 32'h42480000}, {32'h41200000, 32'h41200000}, 1'b0, 1'b0});
    wait_drain(100);
    rsp_ia = 32'h40A00000; rsp_ii = 32'h40400000;
    issue(2'b10, {32'h40000000, 32'h12345678});
    req_q.push_back('{3'd1, 32'h40000000});
    frm_q.push_back('{t_tick, 15, 32'd2, {32'h40A00000, 32'h42480000}, {32'h40400000, 32'h41200000}, 1'b0, 1'b0});
    wait_drain(100);
    issue(2'b00, 64'd0);
    frm_q.push_back('{t_tick, 1, 32'd3, {32'h40A00000, 32'h42480000}, {32'h40400000, 32'h41200000}, 1'b0, 1'b0});
    wait_drain(20);
    skip_n = 1;
    rsp_ia = 32'h43000000; rsp_ii = 32'h42000000;
    issue(2'b11, {32'h41000000, 32'h40800000});
    req_q.push_back('{3'd0, 32'h40800000});
    req_q.push_back('{3'd1, 32'h41000000});
    frm_q.push_back('{t_tick, 1039, 32'd4, {32'h43000000, 32'h42480000}, {32'h42000000, 32'h41200000}, 1'b1, 1'b0});
    wait_drain(1200);
    rsp_ia = 32'h3F000000; rsp_ii = 32'h3E800000;
    issue(2'b11, {32'h3F99999A, 32'h3F800000});
    req_q.push_back('{3'd0, 32'h3F800000});
    req_q.push_back('{3'd1, 32'h3F99999A});
    frm_q.push_back('{t_tick, 26, 32'd5, {32'h3F000000, 32'h3F000000}, {32'h3E800000, 32'h3E800000}, 1'b1, 1'b1});
    repeat (4) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_drain(100);
    repeat (30) @(negedge clk);
    chk("frame_cnt_after_overrun", {32'd0, frame_cnt}, 64'd5);
    rsp_ia = 32'h42C80000; rsp_ii = 32'h42480000;
    issue(2'b11, {32'h3F99999A, 32'h3F800000});
    req_q.push_back('{3'd0, 32'h3F800000});
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("spurious_fr_ia", fr_ia_out, 64'd0);
    chk("spurious_fr_ii", fr_ii_out, 64'd0);
    chk("spurious_busy", {63'd0, busy}, 64'd0);
    chk("spurious_frame_cnt", {32'd0, frame_cnt}, 64'd0);
    issue(2'b11, {32'h3F99999A, 32'h3F800000});
    req_q.push_back('{3'd0, 32'h3F800000});
    req_q.push_back('{3'd1, 32'h3F99999A});
    frm_q.push_back('{t_tick, 26, 32'd1, {32'h42C80000, 32'h42C80000}, {32'h42480000, 32'h42480000}, 1'b0, 1'b0});
    wait_drain(100);
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/spindle_scheduler.md
Name: spindle_scheduler

Overview:
- Time-multiplexes one shared spindle datapath core (bag1/bag2/chain, IEEE-754 single-precision) between NCH muscle channels, e.g. biceps and triceps.
- On each simulation tick it issues one request per enabled channel, in order. It waits for the core's done strobe, then latches that channel's Ia/II firing rates into per-channel output registers.
- Sits between the waveform/length sources and the neuron pools, in the fast clock domain.

Parameters:
- NCH, 2, number of muscle channels sharing the core (1..8).
- TIMEOUT, 1023, max clk cycles to wait for core_done before declaring a fault.
- CW, 3, channel index width; must satisfy 2^CW >= NCH.

Ports:
- clk  input  1  fast system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- tick  input  1  single-cycle pulse, one per simulation step (sim_clk edge already synchronised into clk).
- chan_en  input  NCH  per-channel enable mask; sampled at tick.
- lce_in  input  NCH*32  flattened per-channel muscle length, float; channel i = bits [32i+31:32i].
- core_start  output  1  one-cycle request pulse to the shared core.
- core_chan  output  CW  channel index presented with the request.
- core_lce  output  32  length operand, held stable from core_start until core_done.
- core_done  input  1  one-cycle pulse from the core; results valid the same cycle.
- core_ia  input  32  Ia rate result (float).
- core_ii  input  32  II rate result (float).
- fr_ia_out  output  NCH*32  latched Ia rate per channel.
- fr_ii_out  output  NCH*32  latched II rate per channel.
- frame_done  output  1  one-cycle pulse after the last enabled channel of a tick is serviced.
- busy  output  1  high from tick acceptance until frame_done.
- overrun  output  1  sticky; a tick arrived while busy.
- timeout_err  output  1  sticky; core_done was missing for TIMEOUT cycles.
- frame_cnt  output  32  count of completed frames, wraps at 2^32.

Behaviour:
- Reset (reset=0): all outputs 0; state IDLE; fr_* registers 0 (float 0.0).
- FSM states: IDLE, SCAN, ISSUE, WAIT, DONE.
- IDLE, tick=1:
  - latch chan_en into en_q and lce_in into lce_q (snapshot);
  - set ch=0; busy=1; go to SCAN next cycle.
  - If tick=1 and en mask=0: go directly to DONE; frame_done still pulses and frame_cnt increments.
- SCAN: if ch>=NCH, go to DONE. Else if en_q[ch]=0, increment ch and stay in SCAN (one cycle per skipped channel). Else go to ISSUE.
- ISSUE: core_start=1 for exactly one cycle. core_chan=ch and core_lce=lce_q[ch] are driven from this cycle until leaving WAIT. Clear the timeout counter; go to WAIT.
- WAIT, core_done=1: write core_ia/core_ii into the fr_ia/fr_ii slice of channel ch, visible the next cycle; ch++; go to SCAN.
- WAIT, counter reaches TIMEOUT without core_done: set timeout_err; keep the channel's previous outputs; ch++; go to SCAN.
- core_done outside WAIT: ignored; no register changes.
- DONE: frame_done=1 for one cycle; frame_cnt++; busy=0; go to IDLE.
  - busy deasserts in the same cycle frame_done is high.
- Overrun: tick while busy=1 (including the DONE cycle) sets overrun and the tick is dropped; no queueing.
  - A tick in the first IDLE cycle after DONE is accepted normally.
- chan_en and lce_in changes mid-frame have no effect; the snapshot governs the whole frame.
- Sticky flags clear only on reset.
- Latency with all NCH channels enabled and core latency L (start to done): frame_done asserts 2 + NCH*(L+2) cycles after tick.
  - Each skipped channel adds 1 cycle.
- Async reset mid-frame: immediate return to IDLE; core_start deasserts at once; a later core_done is ignored.

Test Plan:
- NCH=2, both enabled, core model L=10, lce=0x3F800000/0x3F99999A, core returns ia=0x42480000 -> two core_start pulses with core_chan 0 then 1; fr_ia_out slices=0x42480000; frame_done at tick+26; frame_cnt=1.
- chan_en=2'b10 -> single core_start with core_chan=1; channel 0 outputs unchanged; frame_done at tick+15.
- chan_en=0 at tick -> no core_start; frame_done within 2 cycles; frame_cnt increments.
- Core never returns done, TIMEOUT=1023 -> timeout_err=1 after 1023 WAIT cycles; prior outputs retained; next channel serviced; frame_done still pulses.
- Second tick 5 cycles after the first -> overrun=1; exactly one frame_done; frame_cnt=1.
- reset pulsed low during WAIT, then a spurious core_done -> all outputs 0; state IDLE; no fr_* update; next tick runs a full normal frame.
